booth4_mul: RTL and testbench

- Iterative radix-4 Booth multiplier for the RV64 M-extension multiply ops: MUL, MULH, MULHSU and MULHU.
- It is the execute-stage companion to the SRT-4 divider and sits beside it behind the same start/ready handshake.
- Each cycle it retires one Booth digit (−2..+2) of the multiplier.
- Latency is fixed and independent of the data, so the pipeline stall logic stays trivial.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/booth4_recode.sv | 19 +
 rtl/booth4_mul.sv | 120 ++++++++++++
 tb/tb_booth4_mul.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions.
// Used by the Booth multiplier, the divider wrapper and the decode stage:
//   - XLEN / ITER constants
//   - multiply op encodings (funct3[1:0] of the RV64 M-extension multiplies)
//   - common iterative-unit state enum
package mdu_pkg;

    localparam int XLEN = 64;
    localparam int ITER = XLEN / 2 + 1;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/booth4_recode.sv
// Radix-4 Booth digit recoder.
// Ports:
//   win  in  3  multiplier window {b[2i+1], b[2i], b[2i-1]}
//   neg  out 1  digit is negative
//   one  out 1  |digit| == 1
//   two  out 1  |digit| == 2
// A zero digit is one=two=0 (neg is also forced low for 111).
module booth4_recode (
    input  logic [2:0] win,
    output logic       neg,
    output logic       one,
    output logic       two
);

    assign one = win[1] ^ win[0];
    assign two = (win == 3'b011) | (win == 3'b100);
    assign neg = win[2] & ~(win[1] & win[0]);

endmodule

// File: rtl/booth4_mul.sv
// Iterative radix-4 Booth multiplier for MUL / MULH / MULHSU / MULHU.
// Fixed latency: accepted at edge N, ready pulses between edges N+ITER and
// N+ITER+1, independent of the operand values.
// Ports:
//   clock    in   1     clock
//   reset_n  in   1     asynchronous active-low reset
//   start    in   1     request, sampled only in IDLE
//   op       in   2     MUL_OP_* encoding
//   a        in   XLEN  multiplicand (rs1)
//   b        in   XLEN  multiplier (rs2)
//   busy     out  1     high while iterating
//   ready    out  1     one-cycle pulse, result valid
//   result   out  XLEN  selected product half, held until next accepted start
module booth4_mul #(
    parameter int XLEN = mdu_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] result
);
    import mdu_pkg::*;

    localparam int ITERS = XLEN / 2 + 1;
    localparam int EW    = XLEN + 2;     // extended operand width
    localparam int HW    = XLEN + 3;     // accumulator high part (holds +-2x)
    localparam int PW    = HW + EW + 1;  // hi | multiplier | guard bit
    localparam int CW    = $clog2(ITERS);

    mdu_state_e     state;
    logic [1:0]     op_q;
    logic [EW-1:0]  mcand;
    logic [PW-1:0]  acc;
    logic [CW-1:0]  cnt;

    logic           a_sgn, b_sgn;
    logic [EW-1:0]  a_ext, b_ext;
    logic           neg, one, two;
    logic [HW-1:0]  pp, hi_sum;
    logic [PW-1:0]  acc_nxt;

    // Extra two bits make unsigned 64-bit operands representable as signed,
    // so one signed datapath covers all four ops.
    assign a_sgn = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    assign b_sgn = (op == MUL_OP_MULH);
    assign a_ext = {{2{a_sgn & a[XLEN-1]}}, a};
    assign b_ext = {{2{b_sgn & b[XLEN-1]}}, b};

    booth4_recode u_recode (
        .win (acc[2:0]),
        .neg (neg),
        .one (one),
        .two (two)
    );

    always_comb begin
        pp = '0;
        if (one)
            pp = {mcand[EW-1], mcand};
        else if (two)
            pp = {mcand, 1'b0};
        if (neg)
            pp = ~pp + {{(HW-1){1'b0}}, 1'b1};
        hi_sum  = acc[PW-1 -: HW] + pp;
        // Arithmetic shift by 2; the consumed multiplier bit b[2i+1]
        // becomes the next guard bit.
        acc_nxt = {{2{hi_sum[HW-1]}}, hi_sum, acc[EW:2]};
    end

    // After ITERS steps the multiplier is fully shifted out and the exact
    // product sits in acc[PW-1:1].
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            ready  <= 1'b0;
            result <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            op_q   <= MUL_OP_MUL;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        mcand <= a_ext;
                        acc   <= {{HW{1'b0}}, b_ext, 1'b0};
                        cnt   <= CW'(ITERS - 1);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (cnt == '0) begin
                        result <= (op_q == MUL_OP_MUL) ? acc_nxt[XLEN:1]
                                                       : acc_nxt[2*XLEN:XLEN+1];
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth4_mul.sv
module tb_booth4_mul;
    import mdu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [63:0] a, b;
    logic        busy, ready;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    logic [63:0] sb[$];

    booth4_mul dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .ready   (ready),
        .result  (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expected result.
    always @(negedge clock) begin
        if (reset_n && ready) begin
            ready_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                check("result", result, sb.pop_front());
            end
        end
    end

    function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [129:0] xe, ye, p;
        xe = (o == MUL_OP_MULH || o == MUL_OP_MULHSU) ? {{66{x[63]}}, x} : {66'd0, x};
        ye = (o == MUL_OP_MULH) ? {{66{y[63]}}, y} : {66'd0, y};
        p  = xe * ye;
        return (o == MUL_OP_MUL) ? p[63:0] : p[127:64];
    endfunction

    // Issue one op, push its expected result, check busy and the latency.
    task automatic run_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] exp);
        int n;
        @(negedge clock);
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back(exp);
        @(posedge clock);
        #1 start = 1'b0;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clock);
            #1 n++;
        end
        check("latency", 64'(n), 64'd33);
        @(posedge clock);
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] e;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{MUL_OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[1] = '{MUL_OP_MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[2] = '{MUL_OP_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
        vecs[3] = '{MUL_OP_MUL,    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000};
        vecs[4] = '{MUL_OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{MUL_OP_MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[6] = '{MUL_OP_MUL,    64'd7,                   64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[7] = '{MUL_OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'd5,                   64'hFFFF_FFFF_FFFF_FFFF};

        reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #1;
        check("reset_busy",   {63'd0, busy},  64'd0);
        check("reset_ready",  {63'd0, ready}, 64'd0);
        check("reset_result", result,         64'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].e);

        // Handshake: start held high, operand changed during RUN.
        begin
            int r0;
            @(negedge clock);
            op = MUL_OP_MUL; a = 64'd3; b = 64'd5; start = 1'b1;
            sb.push_back(64'd15);
            @(posedge clock);              // edge N
            for (int k = 1; k <= 33; k++) begin
                @(negedge clock);
                if (k == 2) a = 64'd9;
                check("hs_busy",  {63'd0, busy},  64'd1);
                check("hs_ready_low", {63'd0, ready}, 64'd0);
                @(posedge clock);          // edge N+k
            end
            @(negedge clock);
            check("hs_ready",      {63'd0, ready}, 64'd1);
            check("hs_busy_done",  {63'd0, busy},  64'd0);
            @(posedge clock);              // edge N+34: start ignored in DONE
            @(negedge clock);
            start = 1'b0;
            r0 = ready_cnt;
            check("hs_ready_clear", {63'd0, ready}, 64'd0);
            check("hs_no_restart",  {63'd0, busy},  64'd0);
            repeat (40) @(negedge clock);
            check("hs_single_ready", 64'(ready_cnt - r0), 64'd0);
            check("hs_result_held",  result, 64'd15);
        end

        // Reset in the middle of an operation.
        @(negedge clock);
        op = MUL_OP_MUL; a = 64'd11; b = 64'd13; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy",   {63'd0, busy},  64'd0);
        check("rst_mid_ready",  {63'd0, ready}, 64'd0);
        check("rst_mid_result", result,         64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op(MUL_OP_MUL, 64'd6, 64'd7, 64'd42);

        // Random operands, corner values mixed in, against a 128-bit model.
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  o;
            logic [63:0] x, y;
            o = 2'($urandom_range(3));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(7))
                0: x = 64'h8000_0000_0000_0000;
                1: y = 64'hFFFF_FFFF_FFFF_FFFF;
                2: x = 64'd0;
                3: y = 64'h7FFF_FFFF_FFFF_FFFF;
                default: ;
            endcase
            run_op(o, x, y, ref_mul(o, x, y));
        end

        repeat (3) @(negedge clock);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
